// File: rtl/ras_ckpt_stack.sv
// Return-address stack with a speculative copy (fetch-side call/return
// prediction) and an architectural copy (retire). Recovery reloads the
// speculative copy from the architectural next state in one cycle.
module ras_ckpt_stack #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned INDEX = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             specPush_i,
  input  logic [WIDTH-1:0] specPushAddr_i,
  input  logic             specPop_i,
  input  logic             archPush_i,
  input  logic [WIDTH-1:0] archPushAddr_i,
  input  logic             archPop_i,
  input  logic             recoverFlag_i,
  output logic [WIDTH-1:0] tosAddr_o,
  output logic             tosValid_o,
  output logic [INDEX:0]   specCount_o,
  output logic [INDEX:0]   archCount_o,
  output logic             specFull_o
);

  localparam int unsigned CW = INDEX + 1;
  localparam logic [INDEX:0] DEPTH_C = CW'(DEPTH);

  typedef logic [WIDTH-1:0] addr_t;
  typedef logic [INDEX-1:0] ptr_t;
  typedef logic [INDEX:0]   cnt_t;

  // Per-copy update decision: optional ram write plus new pointer/occupancy.
  typedef struct packed {
    logic we;
    ptr_t widx;
    ptr_t ptr;
    cnt_t cnt;
  } upd_t;

  // Shared push/pop rules for both copies.
  function automatic upd_t copy_next(input logic push, input logic pop,
                                     input ptr_t ptr, input cnt_t cnt);
    upd_t u;
    u.we   = 1'b0;
    u.widx = ptr;
    u.ptr  = ptr;
    u.cnt  = cnt;
    if (push && pop && (cnt != '0)) begin
      // Replace TOS in place; pointer and occupancy unchanged.
      u.we   = 1'b1;
      u.widx = ptr - INDEX'(1);
    end else if (push) begin
      // Wraps over the oldest entry when full; occupancy saturates.
      u.we   = 1'b1;
      u.widx = ptr;
      u.ptr  = ptr + INDEX'(1);
      u.cnt  = (cnt == DEPTH_C) ? cnt : cnt + CW'(1);
    end else if (pop && (cnt != '0)) begin
      u.ptr = ptr - INDEX'(1);
      u.cnt = cnt - CW'(1);
    end
    return u;
  endfunction

  addr_t spec_ram_q [DEPTH];
  addr_t spec_ram_d [DEPTH];
  ptr_t  spec_ptr_q, spec_ptr_d;
  cnt_t  spec_cnt_q, spec_cnt_d;

  addr_t arch_ram_q [DEPTH];
  addr_t arch_ram_d [DEPTH];
  ptr_t  arch_ptr_q, arch_ptr_d;
  cnt_t  arch_cnt_q, arch_cnt_d;

  upd_t  arch_upd;
  upd_t  spec_upd;

  // Architectural next state from retired calls/returns only.
  always_comb begin
    arch_upd   = copy_next(archPush_i, archPop_i, arch_ptr_q, arch_cnt_q);
    arch_ram_d = arch_ram_q;
    arch_ptr_d = arch_upd.ptr;
    arch_cnt_d = arch_upd.cnt;
    if (arch_upd.we) begin
      arch_ram_d[arch_upd.widx] = archPushAddr_i;
    end
  end

  // Speculative next state; recovery copies the arch next state (write forwarded).
  always_comb begin
    spec_upd   = copy_next(specPush_i, specPop_i, spec_ptr_q, spec_cnt_q);
    spec_ram_d = spec_ram_q;
    spec_ptr_d = spec_upd.ptr;
    spec_cnt_d = spec_upd.cnt;
    if (recoverFlag_i) begin
      spec_ram_d = arch_ram_d;
      spec_ptr_d = arch_ptr_d;
      spec_cnt_d = arch_cnt_d;
    end else if (spec_upd.we) begin
      spec_ram_d[spec_upd.widx] = specPushAddr_i;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      spec_ram_q <= '{default: '0};
      spec_ptr_q <= '0;
      spec_cnt_q <= '0;
      arch_ram_q <= '{default: '0};
      arch_ptr_q <= '0;
      arch_cnt_q <= '0;
    end else begin
      spec_ram_q <= spec_ram_d;
      spec_ptr_q <= spec_ptr_d;
      spec_cnt_q <= spec_cnt_d;
      arch_ram_q <= arch_ram_d;
      arch_ptr_q <= arch_ptr_d;
      arch_cnt_q <= arch_cnt_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    tosValid_o  = (spec_cnt_q != '0);
    tosAddr_o   = tosValid_o ? spec_ram_q[spec_ptr_q - INDEX'(1)] : '0;
    specCount_o = spec_cnt_q;
    archCount_o = arch_cnt_q;
    specFull_o  = (spec_cnt_q == DEPTH_C);
  end

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Bench for ras_ckpt_stack: directed vector table plus randomized traffic
// checked against a queue-based model of both stack copies.
module tb_ras_ckpt_stack;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned INDEX = 4;
  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             specPush_i;
  logic [WIDTH-1:0] specPushAddr_i;
  logic             specPop_i;
  logic             archPush_i;
  logic [WIDTH-1:0] archPushAddr_i;
  logic             archPop_i;
  logic             recoverFlag_i;
  logic [WIDTH-1:0] tosAddr_o;
  logic             tosValid_o;
  logic [INDEX:0]   specCount_o;
  logic [INDEX:0]   archCount_o;
  logic             specFull_o;

  ras_ckpt_stack #(.DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .specPush_i     (specPush_i),
    .specPushAddr_i (specPushAddr_i),
    .specPop_i      (specPop_i),
    .archPush_i     (archPush_i),
    .archPushAddr_i (archPushAddr_i),
    .archPop_i      (archPop_i),
    .recoverFlag_i  (recoverFlag_i),
    .tosAddr_o      (tosAddr_o),
    .tosValid_o     (tosValid_o),
    .specCount_o    (specCount_o),
    .archCount_o    (archCount_o),
    .specFull_o     (specFull_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        sps;
    logic [31:0] spa;
    logic        spp;
    logic        aps;
    logic [31:0] apa;
    logic        app;
    logic        rec;
    logic [31:0] tos;
    logic [4:0]  sc;
    logic [4:0]  ac;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: newest entry at the back of each queue.
  logic [31:0] spec_q[$];
  logic [31:0] arch_q[$];

  function automatic vec_t mk(logic rst, logic sps, logic [31:0] spa, logic spp,
                              logic aps, logic [31:0] apa, logic app, logic rec,
                              logic [31:0] tos, logic [4:0] sc, logic [4:0] ac);
    vec_t v;
    v.rst = rst; v.sps = sps; v.spa = spa; v.spp = spp;
    v.aps = aps; v.apa = apa; v.app = app; v.rec = rec;
    v.tos = tos; v.sc = sc; v.ac = ac;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic sps, input logic [31:0] spa,
                       input logic spp, input logic aps, input logic [31:0] apa,
                       input logic app, input logic rec);
    @(negedge clk);
    reset = rst; specPush_i = sps; specPushAddr_i = spa; specPop_i = spp;
    archPush_i = aps; archPushAddr_i = apa; archPop_i = app; recoverFlag_i = rec;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] tos,
                               input logic [4:0] sc, input logic [4:0] ac);
    chk({tag, ".tos"},   tosAddr_o, tos);
    chk({tag, ".valid"}, 32'(tosValid_o), 32'(sc != 5'd0));
    chk({tag, ".scnt"},  32'(specCount_o), 32'(sc));
    chk({tag, ".acnt"},  32'(archCount_o), 32'(ac));
    chk({tag, ".full"},  32'(specFull_o), 32'(sc == 5'(DEPTH)));
  endtask

  task automatic model_step(input logic rst, input logic sps, input logic [31:0] spa,
                            input logic spp, input logic aps, input logic [31:0] apa,
                            input logic app, input logic rec);
    if (rst) begin
      spec_q.delete();
      arch_q.delete();
    end else begin
      if (aps && app && arch_q.size() > 0) arch_q[arch_q.size()-1] = apa;
      else if (aps) begin
        arch_q.push_back(apa);
        if (arch_q.size() > DEPTH) void'(arch_q.pop_front());
      end else if (app && arch_q.size() > 0) void'(arch_q.pop_back());
      if (rec) spec_q = arch_q;
      else if (sps && spp && spec_q.size() > 0) spec_q[spec_q.size()-1] = spa;
      else if (sps) begin
        spec_q.push_back(spa);
        if (spec_q.size() > DEPTH) void'(spec_q.pop_front());
      end else if (spp && spec_q.size() > 0) void'(spec_q.pop_back());
    end
  endtask

  initial begin
    reset = 1'b1; specPush_i = 1'b0; specPushAddr_i = '0; specPop_i = 1'b0;
    archPush_i = 1'b0; archPushAddr_i = '0; archPop_i = 1'b0; recoverFlag_i = 1'b0;

    // Basic push/pop
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 32'h0,   0, 0));
    tbl.push_back(mk(0,1,32'h100,0, 0,0,0,0, 32'h100, 1, 0));
    tbl.push_back(mk(0,1,32'h200,0, 0,0,0,0, 32'h200, 2, 0));
    tbl.push_back(mk(0,1,32'h300,0, 0,0,0,0, 32'h300, 3, 0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h200, 2, 0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h100, 1, 0));
    // Overflow wrap: 17 pushes, then 16 pops
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 32'h0, 0, 0));
    for (int i = 1; i <= 17; i++)
      tbl.push_back(mk(0,1,32'(i),0, 0,0,0,0, 32'(i), 5'((i > 16) ? 16 : i), 0));
    for (int k = 1; k <= 16; k++)
      tbl.push_back(mk(0,0,0,1, 0,0,0,0, (k == 16) ? 32'h0 : 32'(17 - k), 5'(16 - k), 0));
    // Underflow protection
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h0, 0, 0));
    tbl.push_back(mk(0,1,32'hA,0, 0,0,0,0, 32'hA, 1, 0));
    // Pop+push replaces TOS
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 32'h0, 0, 0));
    tbl.push_back(mk(0,1,32'h10,0, 0,0,0,0, 32'h10, 1, 0));
    tbl.push_back(mk(0,1,32'h20,0, 0,0,0,0, 32'h20, 2, 0));
    tbl.push_back(mk(0,1,32'h99,1, 0,0,0,0, 32'h99, 2, 0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h10, 1, 0));
    // Recovery with forwarded arch push
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 32'h0, 0, 0));
    tbl.push_back(mk(0,0,0,0, 1,32'h40,0,0, 32'h0, 0, 1));
    tbl.push_back(mk(0,0,0,0, 1,32'h50,0,0, 32'h0, 0, 2));
    tbl.push_back(mk(0,1,32'h60,0, 0,0,0,0, 32'h60, 1, 2));
    tbl.push_back(mk(0,1,32'h70,0, 0,0,0,0, 32'h70, 2, 2));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h60, 1, 2));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h0, 0, 2));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h0, 0, 2));
    tbl.push_back(mk(0,1,32'hDEAD,1, 1,32'h80,0,1, 32'h80, 3, 3));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h50, 2, 3));
    tbl.push_back(mk(0,0,0,1, 0,0,0,0, 32'h40, 1, 3));
    // Back-to-back recovery repeats the copy
    tbl.push_back(mk(0,0,0,0, 0,0,1,1, 32'h50, 2, 2));
    tbl.push_back(mk(0,1,32'h77,0, 0,0,0,1, 32'h50, 2, 2));
    // Reset overrides push and recover
    tbl.push_back(mk(1,1,32'h123,0, 1,32'h456,0,1, 32'h0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].sps, tbl[i].spa, tbl[i].spp,
            tbl[i].aps, tbl[i].apa, tbl[i].app, tbl[i].rec);
      check_outputs($sformatf("vec%0d", i), tbl[i].tos, tbl[i].sc, tbl[i].ac);
    end

    // Outputs must not follow inputs between edges.
    @(negedge clk);
    specPush_i = 1'b1; specPushAddr_i = 32'hBEEF; archPush_i = 1'b1; recoverFlag_i = 1'b1;
    #2;
    check_outputs("no_comb_path", 32'h0, 0, 0);

    // Randomized traffic against the queue model (model empty after last reset).
    spec_q.delete();
    arch_q.delete();
    for (int n = 0; n < 800; n++) begin
      logic rst, sps, spp, aps, app, rec;
      logic [31:0] spa, apa, etos;
      rst = ($urandom_range(0, 199) == 0);
      sps = ($urandom_range(0, 99) < 55);
      spp = ($urandom_range(0, 99) < 40);
      aps = ($urandom_range(0, 99) < 50);
      app = ($urandom_range(0, 99) < 40);
      rec = ($urandom_range(0, 99) < 6);
      spa = $urandom;
      apa = $urandom;
      drive(rst, sps, spa, spp, aps, apa, app, rec);
      model_step(rst, sps, spa, spp, aps, apa, app, rec);
      etos = (spec_q.size() > 0) ? spec_q[spec_q.size()-1] : 32'h0;
      check_outputs($sformatf("rnd%0d", n), etos, 5'(spec_q.size()), 5'(arch_q.size()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
